grf_wr_arbiter: RTL and testbench

- Shares the single GRF write port (A3/WD3/Enabled/PC) between two write sources:
  - port 0: the pipeline W stage.
  - port 1: the multi-cycle mult/div unit result path.
- Buffers each source in a small FIFO and arbitrates with port-0 priority plus an anti-starvation age counter.
- Exports a pending-write scoreboard that decode uses for stall decisions.

---
 rtl/grf_pkg.sv | 35 +++
 rtl/grf_wr_fifo.sv | 97 +++++++++
 rtl/grf_wr_arbiter.sv | 213 +++++++++++++++++++++
 tb/tb_grf_wr_arbiter.sv | 239 +++++++++++++++++++++++
 4 files changed

// File: rtl/grf_pkg.sv
`default_nettype none
// ============================================================================
// Module      : grf_pkg
// Description : Shared types for the GRF write-port arbiter slice. Holds the
//               register/data widths, the buffered write-entry layout, the
//               write-source tag and a sizing helper for the age counter.
// Revision    : 1.0 - initial release
// ============================================================================
package grf_pkg;

  localparam int REG_AW = 5;
  localparam int DATA_W = 32;

  // One buffered GRF write: destination, value and the PC of the producer.
  typedef struct packed {
    logic [REG_AW-1:0] addr;
    logic [DATA_W-1:0] data;
    logic [DATA_W-1:0] pc;
  } grf_entry_t;

  // Write source tag: port 0 is the pipeline W stage, port 1 the mult/div unit.
  typedef enum logic {
    SRC_PIPE = 1'b0,
    SRC_MDU  = 1'b1
  } grf_src_e;

  // Age counter width: wide enough to hold STARVE_LIMIT, never below 3 bits.
  function automatic int age_width(input int limit);
    int w;
    w = $clog2(limit + 1);
    return (w < 3) ? 3 : w;
  endfunction

endpackage : grf_pkg
`default_nettype wire

// File: rtl/grf_wr_fifo.sv
`default_nettype none
// ============================================================================
// Module      : grf_wr_fifo
// Description : Small circular FIFO of GRF write entries, one per write
//               source. Besides the usual head/empty/full interface it exposes
//               a per-entry valid bit and destination address so the arbiter
//               can run cross-port hazard checks and the pending scoreboard.
// Revision    : 1.0 - initial release
//
// Parameters  : DEPTH        entries (power of 2, >= 2)
// Ports       : clk          clock, rising edge
//               reset        asynchronous active-low reset
//               push         enqueue request (ignored when full)
//               push_entry   entry to enqueue
//               pop          dequeue request (ignored when empty)
//               head         oldest entry
//               empty, full  occupancy flags (registered count)
//               entry_valid  per-slot occupancy
//               entry_addr   per-slot destination register
// ============================================================================
module grf_wr_fifo
  import grf_pkg::*;
#(
  parameter int DEPTH = 2
) (
  input  logic                          clk,
  input  logic                          reset,
  input  logic                          push,
  input  grf_entry_t                    push_entry,
  input  logic                          pop,
  output grf_entry_t                    head,
  output logic                          empty,
  output logic                          full,
  output logic [DEPTH-1:0]              entry_valid,
  output logic [DEPTH-1:0][REG_AW-1:0]  entry_addr
);

  localparam int c_PTR_W = $clog2(DEPTH);
  localparam int c_CNT_W = c_PTR_W + 1;

  grf_entry_t           r_mem [DEPTH];
  logic [c_PTR_W-1:0]   r_wr_ptr;
  logic [c_PTR_W-1:0]   r_rd_ptr;
  logic [c_CNT_W-1:0]   r_count;
  logic [DEPTH-1:0]     r_valid;

  logic w_do_push;
  logic w_do_pop;

  assign empty     = (r_count == '0);
  assign full      = (r_count == c_CNT_W'(DEPTH));
  assign w_do_push = push && !full;
  assign w_do_pop  = pop && !empty;
  assign head      = r_mem[r_rd_ptr];

  // DEPTH is a power of two, so the pointers wrap by plain overflow.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
      r_valid  <= '0;
      for (int i = 0; i < DEPTH; i++) begin
        r_mem[i] <= '0;
      end
    end else begin
      if (w_do_push) begin
        r_mem[r_wr_ptr] <= push_entry;
        r_wr_ptr        <= r_wr_ptr + 1'b1;
      end
      if (w_do_pop) begin
        r_rd_ptr <= r_rd_ptr + 1'b1;
      end
      case ({w_do_push, w_do_pop})
        2'b10:   r_count <= r_count + 1'b1;
        2'b01:   r_count <= r_count - 1'b1;
        default: r_count <= r_count;
      endcase
      // A simultaneous push and pop always touch different slots: the FIFO is
      // then neither empty nor full, so the pointers differ.
      if (w_do_pop) begin
        r_valid[r_rd_ptr] <= 1'b0;
      end
      if (w_do_push) begin
        r_valid[r_wr_ptr] <= 1'b1;
      end
    end
  end

  assign entry_valid = r_valid;

  for (genvar i = 0; i < DEPTH; i++) begin : g_entry_addr
    assign entry_addr[i] = r_mem[i].addr;
  end

endmodule : grf_wr_fifo
`default_nettype wire

// File: rtl/grf_wr_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : grf_wr_arbiter
// Description : Shares the single GRF write port between the pipeline W stage
//               (port 0) and the mult/div result path (port 1). Each source is
//               buffered in a grf_wr_fifo; port 0 has priority, with an age
//               counter forcing port 1 through after STARVE_LIMIT losses.
//               Also exports a pending-write scoreboard for decode stalls.
// Revision    : 1.0 - initial release
//
// Build macro : GRF_WR_TRACE_EN - when defined, each committing write to a
//               non-zero register is printed with its source tag.
//
// Parameters  : DEPTH         entries per source FIFO (power of 2, >= 2)
//               STARVE_LIMIT  losses port 1 tolerates before it is forced
// Ports       : clk, reset                       clock / async active-low reset
//               w0_valid/addr/data/pc, w0_ready  pipeline write request
//               w1_valid/addr/data/pc, w1_ready  MDU write request
//               grf_en/a3/wd/pc                  registered GRF write port
//               q_rs, q_rt                       decode query addresses
//               rs_pending, rt_pending           uncommitted write to query
// ============================================================================
module grf_wr_arbiter
  import grf_pkg::*;
#(
  parameter int DEPTH        = 2,
  parameter int STARVE_LIMIT = 4
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              w0_valid,
  input  logic [REG_AW-1:0] w0_addr,
  input  logic [DATA_W-1:0] w0_data,
  input  logic [DATA_W-1:0] w0_pc,
  output logic              w0_ready,
  input  logic              w1_valid,
  input  logic [REG_AW-1:0] w1_addr,
  input  logic [DATA_W-1:0] w1_data,
  input  logic [DATA_W-1:0] w1_pc,
  output logic              w1_ready,
  output logic              grf_en,
  output logic [REG_AW-1:0] grf_a3,
  output logic [DATA_W-1:0] grf_wd,
  output logic [DATA_W-1:0] grf_pc,
  input  logic [REG_AW-1:0] q_rs,
  input  logic [REG_AW-1:0] q_rt,
  output logic              rs_pending,
  output logic              rt_pending
);

  localparam int c_AGE_W = age_width(STARVE_LIMIT);

  // FIFO interfaces
  grf_entry_t                   w_push0_entry, w_push1_entry;
  grf_entry_t                   w_head0, w_head1, w_win;
  logic                         w_push0, w_push1;
  logic                         w_empty0, w_empty1;
  logic                         w_full0, w_full1;
  logic [DEPTH-1:0]             w_f0_valid, w_f1_valid;
  logic [DEPTH-1:0][REG_AW-1:0] w_f0_addr, w_f1_addr;

  // Hazard / scoreboard terms
  logic [DEPTH-1:0] w_w0_hits_f1, w_w1_hits_f0;
  logic [DEPTH-1:0] w_rs_hits, w_rt_hits;
  logic             w_w0_zero, w_w1_zero;

  // Arbitration
  logic               w_force1, w_grant0, w_grant1;
  logic [c_AGE_W-1:0] r_age;

  // Output register
  logic              r_grf_en;
  logic [REG_AW-1:0] r_grf_a3;
  logic [DATA_W-1:0] r_grf_wd;
  logic [DATA_W-1:0] r_grf_pc;

  // --------------------------------------------------------------------------
  // Cross-port address matching and scoreboard hits, one term per FIFO slot
  // --------------------------------------------------------------------------
  for (genvar i = 0; i < DEPTH; i++) begin : g_match
    assign w_w0_hits_f1[i] = w_f1_valid[i] && (w_f1_addr[i] == w0_addr);
    assign w_w1_hits_f0[i] = w_f0_valid[i] && (w_f0_addr[i] == w1_addr);
    assign w_rs_hits[i]    = (w_f0_valid[i] && (w_f0_addr[i] == q_rs)) ||
                             (w_f1_valid[i] && (w_f1_addr[i] == q_rs));
    assign w_rt_hits[i]    = (w_f0_valid[i] && (w_f0_addr[i] == q_rt)) ||
                             (w_f1_valid[i] && (w_f1_addr[i] == q_rt));
  end

  // --------------------------------------------------------------------------
  // Accept logic. $0 writes are swallowed on the spot. Otherwise a source may
  // only enqueue a register that the other source has no pending write to, so
  // all pending writes to one register live in one FIFO and commit in order.
  // Port 1 also yields to a same-cycle port-0 request for the same register.
  // --------------------------------------------------------------------------
  assign w_w0_zero = (w0_addr == '0);
  assign w_w1_zero = (w1_addr == '0);

  assign w0_ready = w_w0_zero || (!w_full0 && !(|w_w0_hits_f1));
  assign w1_ready = w_w1_zero || (!w_full1 && !(|w_w1_hits_f0) &&
                                  !(w0_valid && (w0_addr == w1_addr)));

  assign w_push0 = w0_valid && w0_ready && !w_w0_zero;
  assign w_push1 = w1_valid && w1_ready && !w_w1_zero;

  assign w_push0_entry = '{addr: w0_addr, data: w0_data, pc: w0_pc};
  assign w_push1_entry = '{addr: w1_addr, data: w1_data, pc: w1_pc};

  grf_wr_fifo #(
    .DEPTH(DEPTH)
  ) u_fifo0 (
    .clk        (clk),
    .reset      (reset),
    .push       (w_push0),
    .push_entry (w_push0_entry),
    .pop        (w_grant0),
    .head       (w_head0),
    .empty      (w_empty0),
    .full       (w_full0),
    .entry_valid(w_f0_valid),
    .entry_addr (w_f0_addr)
  );

  grf_wr_fifo #(
    .DEPTH(DEPTH)
  ) u_fifo1 (
    .clk        (clk),
    .reset      (reset),
    .push       (w_push1),
    .push_entry (w_push1_entry),
    .pop        (w_grant1),
    .head       (w_head1),
    .empty      (w_empty1),
    .full       (w_full1),
    .entry_valid(w_f1_valid),
    .entry_addr (w_f1_addr)
  );

  // --------------------------------------------------------------------------
  // Arbitration: port 0 first, unless port 1 has lost STARVE_LIMIT times in a
  // row. The empty1 term is redundant with how the age counter evolves but
  // keeps the override from ever granting an empty FIFO.
  // --------------------------------------------------------------------------
  assign w_force1 = (r_age == c_AGE_W'(STARVE_LIMIT)) && !w_empty1;
  assign w_grant0 = !w_empty0 && !w_force1;
  assign w_grant1 = !w_empty1 && !w_grant0;
  assign w_win    = w_grant0 ? w_head0 : w_head1;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_age <= '0;
    end else if (w_empty1 || w_grant1) begin
      r_age <= '0;
    end else if (r_age != c_AGE_W'(STARVE_LIMIT)) begin
      r_age <= r_age + 1'b1;
    end
  end

  // --------------------------------------------------------------------------
  // GRF write-port register. Address/data/pc hold their last value when idle;
  // only grf_en qualifies them.
  // --------------------------------------------------------------------------
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_grf_en <= 1'b0;
      r_grf_a3 <= '0;
      r_grf_wd <= '0;
      r_grf_pc <= '0;
    end else begin
      r_grf_en <= w_grant0 || w_grant1;
      if (w_grant0 || w_grant1) begin
        r_grf_a3 <= w_win.addr;
        r_grf_wd <= w_win.data;
        r_grf_pc <= w_win.pc;
      end
    end
  end

  assign grf_en = r_grf_en;
  assign grf_a3 = r_grf_a3;
  assign grf_wd = r_grf_wd;
  assign grf_pc = r_grf_pc;

  // --------------------------------------------------------------------------
  // Pending scoreboard: any buffered entry or the write currently on the GRF
  // port. $0 is never reported as pending.
  // --------------------------------------------------------------------------
  assign rs_pending = (q_rs != '0) &&
                      ((|w_rs_hits) || (r_grf_en && (r_grf_a3 == q_rs)));
  assign rt_pending = (q_rt != '0) &&
                      ((|w_rt_hits) || (r_grf_en && (r_grf_a3 == q_rt)));

`ifdef GRF_WR_TRACE_EN
  // Source tag of the write held in the output register, for the trace only.
  grf_src_e r_out_src;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_out_src <= SRC_PIPE;
    end else if (w_grant0 || w_grant1) begin
      r_out_src <= w_grant0 ? SRC_PIPE : SRC_MDU;
    end
  end

  always @(posedge clk) begin
    if (reset && r_grf_en && (r_grf_a3 != '0)) begin
      $display("@%h: $%d <= %h  src=%s", r_grf_pc, r_grf_a3, r_grf_wd,
               r_out_src.name());
    end
  end
`endif

endmodule : grf_wr_arbiter
`default_nettype wire

// File: tb/tb_grf_wr_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : tb_grf_wr_arbiter
// Description : Directed self-checking bench for grf_wr_arbiter (DEPTH=2,
//               STARVE_LIMIT=4). Inputs are driven 1 time unit after each
//               rising edge; outputs are sampled at the same point.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_grf_wr_arbiter;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic        w0_valid, w1_valid;
  logic [4:0]  w0_addr, w1_addr;
  logic [31:0] w0_data, w1_data, w0_pc, w1_pc;
  logic        w0_ready, w1_ready;
  logic        grf_en;
  logic [4:0]  grf_a3;
  logic [31:0] grf_wd, grf_pc;
  logic [4:0]  q_rs, q_rt;
  logic        rs_pending, rt_pending;

  int n_tests = 0;
  int n_fail  = 0;

  grf_wr_arbiter #(
    .DEPTH       (2),
    .STARVE_LIMIT(4)
  ) dut (
    .clk       (clk),
    .reset     (reset),
    .w0_valid  (w0_valid),
    .w0_addr   (w0_addr),
    .w0_data   (w0_data),
    .w0_pc     (w0_pc),
    .w0_ready  (w0_ready),
    .w1_valid  (w1_valid),
    .w1_addr   (w1_addr),
    .w1_data   (w1_data),
    .w1_pc     (w1_pc),
    .w1_ready  (w1_ready),
    .grf_en    (grf_en),
    .grf_a3    (grf_a3),
    .grf_wd    (grf_wd),
    .grf_pc    (grf_pc),
    .q_rs      (q_rs),
    .q_rt      (q_rt),
    .rs_pending(rs_pending),
    .rt_pending(rt_pending)
  );

  always #5 clk = ~clk;

  initial begin
    #20000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    assert (obs === exp)
    else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  logic [4:0]  exp_a3  [12];
  logic        exp_rdy [12];
  int          cnt0, cnt1, commit0, commit1, waited;
  logic        acc0, acc1;
  logic [31:0] exp_wd;

  initial begin
    w0_valid = 1'b0; w0_addr = '0; w0_data = '0; w0_pc = '0;
    w1_valid = 1'b0; w1_addr = '0; w1_data = '0; w1_pc = '0;
    q_rs = '0; q_rt = '0;

    // ---------------- reset state ----------------
    repeat (3) @(posedge clk);
    #1;
    chk("rst_en", grf_en, 0);
    chk("rst_a3", grf_a3, 0);
    chk("rst_wd", grf_wd, 0);
    chk("rst_pc", grf_pc, 0);
    reset = 1'b1;
    #1;
    chk("rst_w0_ready", w0_ready, 1);
    chk("rst_w1_ready", w1_ready, 1);
    step();

    // ---------------- single port-0 write, latency and pending ----------------
    q_rs = 5'd5;
    w0_valid = 1'b1; w0_addr = 5'd5; w0_data = 32'h0000_1234; w0_pc = 32'h0000_3000;
    #1;
    chk("t1_pend_pre", rs_pending, 0);
    step();                              // edge k: accepted
    w0_valid = 1'b0;
    chk("t1_en_k", grf_en, 0);
    chk("t1_pend_k", rs_pending, 1);
    step();                              // edge k+1: on the GRF port
    chk("t1_en_k1", grf_en, 1);
    chk("t1_a3", grf_a3, 5);
    chk("t1_wd", grf_wd, 32'h0000_1234);
    chk("t1_pc", grf_pc, 32'h0000_3000);
    chk("t1_pend_k1", rs_pending, 1);
    step();                              // edge k+2: committed
    chk("t1_en_k2", grf_en, 0);
    chk("t1_pend_k2", rs_pending, 0);

    // ---------------- same-cycle same-register: port 1 yields ----------------
    w0_valid = 1'b1; w0_addr = 5'd12;
    w1_valid = 1'b1; w1_addr = 5'd12;
    #1;
    chk("tc_w1_ready", w1_ready, 0);
    chk("tc_w0_ready", w0_ready, 1);
    w0_valid = 1'b0; w1_valid = 1'b0;
    step();

    // ---------------- port 1 holds $7, port 0 must wait ----------------
    w1_valid = 1'b1; w1_addr = 5'd7; w1_data = 32'h7777_0001; w1_pc = 32'h0000_4000;
    step();                              // edge a: port 1 enqueued
    w1_valid = 1'b0;
    w0_valid = 1'b1; w0_addr = 5'd7; w0_data = 32'h7777_0000; w0_pc = 32'h0000_4004;
    #1;
    chk("t3_w0_blocked", w0_ready, 0);
    step();                              // edge a+1: port 1 popped
    chk("t3_en1", grf_en, 1);
    chk("t3_wd1", grf_wd, 32'h7777_0001);
    chk("t3_w0_ready", w0_ready, 1);
    step();                              // edge a+2: port 0 accepted
    w0_valid = 1'b0;
    chk("t3_en_gap", grf_en, 0);
    step();                              // edge a+3: port 0 on the GRF port
    chk("t3_en2", grf_en, 1);
    chk("t3_wd2", grf_wd, 32'h7777_0000);
    chk("t3_pc2", grf_pc, 32'h0000_4004);

    // ---------------- $0 write is swallowed ----------------
    q_rs = 5'd0;
    w0_valid = 1'b1; w0_addr = 5'd0; w0_data = 32'h0000_FFFF; w0_pc = 32'h0000_5000;
    #1;
    chk("t4_ready", w0_ready, 1);
    chk("t4_pend0", rs_pending, 0);
    step();
    w0_valid = 1'b0;
    chk("t4_en_a", grf_en, 0);
    step();
    chk("t4_en_b", grf_en, 0);
    step();
    chk("t4_en_c", grf_en, 0);
    chk("t4_pend1", rs_pending, 0);

    // ---------------- both ports every cycle: starvation, fill, wrap ----------------
    // Port 1 wins one grant in every five; port 0 fills to DEPTH whenever it
    // loses and otherwise sits at DEPTH-1 with push+pop on the same edge.
    exp_a3[0]  = 5'd0; exp_a3[1]  = 5'd0;
    exp_a3[2]  = 5'd8; exp_a3[3]  = 5'd8; exp_a3[4]  = 5'd8; exp_a3[5]  = 5'd8;
    exp_a3[6]  = 5'd9;
    exp_a3[7]  = 5'd8; exp_a3[8]  = 5'd8; exp_a3[9]  = 5'd8; exp_a3[10] = 5'd8;
    exp_a3[11] = 5'd9;
    exp_rdy[0] = 1'b1;
    for (int e = 1; e < 12; e++) exp_rdy[e] = ((e == 6) || (e == 11)) ? 1'b0 : 1'b1;
    q_rs = 5'd8; q_rt = 5'd9;
    cnt0 = 0; cnt1 = 0; commit0 = 0; commit1 = 0;
    for (int e = 1; e < 12; e++) begin
      w0_valid = 1'b1; w0_addr = 5'd8;
      w0_data = 32'h1000_0000 + cnt0; w0_pc = 32'h0000_6000 + cnt0 * 4;
      w1_valid = 1'b1; w1_addr = 5'd9;
      w1_data = 32'h2000_0000 + cnt1; w1_pc = 32'h0000_7000 + cnt1 * 4;
      #1;
      acc0 = w0_ready;
      acc1 = w1_ready;
      step();
      if (acc0) cnt0++;
      if (acc1) cnt1++;
      chk($sformatf("t2_w0_ready_e%0d", e), w0_ready, exp_rdy[e]);
      if (e >= 2) begin
        chk($sformatf("t2_en_e%0d", e), grf_en, 1);
        chk($sformatf("t2_a3_e%0d", e), grf_a3, exp_a3[e]);
        if (exp_a3[e] == 5'd8) begin
          exp_wd = 32'h1000_0000 + commit0;
          commit0++;
        end else begin
          exp_wd = 32'h2000_0000 + commit1;
          commit1++;
        end
        chk($sformatf("t2_wd_e%0d", e), grf_wd, exp_wd);
      end
    end
    w0_valid = 1'b0; w1_valid = 1'b0;
    waited = 0;
    while ((rs_pending || rt_pending) && waited < 20) begin
      step();
      waited++;
    end
    chk("t2_drain_pend", {rs_pending, rt_pending}, 0);
    chk("t2_drain_en", grf_en, 0);

    // ---------------- reset mid-burst ----------------
    q_rs = 5'd10; q_rt = 5'd11;
    w0_valid = 1'b1; w0_addr = 5'd10; w0_data = 32'hAAAA_0000; w0_pc = 32'h0000_8000;
    w1_valid = 1'b1; w1_addr = 5'd11; w1_data = 32'hBBBB_0000; w1_pc = 32'h0000_9000;
    step();
    step();
    chk("t6_en_pre", grf_en, 1);
    chk("t6_rs_pre", rs_pending, 1);
    chk("t6_rt_pre", rt_pending, 1);
    #2;
    reset = 1'b0;
    #1;
    chk("t6_en_rst", grf_en, 0);
    chk("t6_a3_rst", grf_a3, 0);
    chk("t6_rs_rst", rs_pending, 0);
    chk("t6_rt_rst", rt_pending, 0);
    w0_valid = 1'b0; w1_valid = 1'b0;
    step();
    #1;
    reset = 1'b1;
    step();
    chk("t6_en_post1", grf_en, 0);
    step();
    chk("t6_en_post2", grf_en, 0);
    chk("t6_w0_ready", w0_ready, 1);
    chk("t6_w1_ready", w1_ready, 1);
    chk("t6_pend_post", {rs_pending, rt_pending}, 0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule : tb_grf_wr_arbiter
`default_nettype wire
